vld_rdy_distributor: RTL and testbench

Valid/ready broadcast fork: each upstream token is delivered exactly once to each of two downstream consumers. The upstream handshake completes only after both consumers have accepted the token. Consumers may accept it in the same cycle or in different cycles. The block carries no data; it sits between a producer and two independent consumers that share a payload routed alongside the handshake.

---
 rtl/vld_rdy_distributor.sv | 53 +++++
 tb/tb_vld_rdy_distributor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vld_rdy_distributor.sv
// Valid/ready broadcast fork: every upstream token goes to two consumers exactly once.
// Upstream retires the token only when both consumers have taken it, in any order.
module vld_rdy_distributor (
  input  logic clock,
  input  logic reset,
  input  logic up_valid,
  output logic up_ready,
  output logic dn1_valid,
  input  logic dn1_ready,
  output logic dn2_valid,
  input  logic dn2_ready
);

  logic done1_q, done2_q;
  logic done1_d, done2_d;
  logic up_fire, dn1_fire, dn2_fire;

  // doneK marks that consumer K already holds the current token
  always_comb begin
    dn1_valid = 1'b0;
    dn2_valid = 1'b0;
    up_ready  = 1'b0;
    if (!reset) begin
      dn1_valid = up_valid & ~done1_q;
      dn2_valid = up_valid & ~done2_q;
      up_ready  = (done1_q | dn1_ready) & (done2_q | dn2_ready);
    end
  end

  assign up_fire  = up_valid  & up_ready;
  assign dn1_fire = dn1_valid & dn1_ready;
  assign dn2_fire = dn2_valid & dn2_ready;

  always_comb begin
    done1_d = done1_q | dn1_fire;
    done2_d = done2_q | dn2_fire;
    if (up_fire) begin
      done1_d = 1'b0;
      done2_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done1_q <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      done1_q <= done1_d;
      done2_q <= done2_d;
    end
  end

endmodule

// File: tb/tb_vld_rdy_distributor.sv
// Randomized scoreboard bench for vld_rdy_distributor using a token-count reference model.
module tb_vld_rdy_distributor;

  logic clock = 1'b0;
  logic reset, up_valid, dn1_ready, dn2_ready;
  logic up_ready, dn1_valid, dn2_valid;

  vld_rdy_distributor dut (
    .clock    (clock),
    .reset    (reset),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .dn1_valid(dn1_valid),
    .dn1_ready(dn1_ready),
    .dn2_valid(dn2_valid),
    .dn2_ready(dn2_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic upr;
    logic d1v;
    logic d2v;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: tokens retired upstream, and tokens each consumer has received.
  int ups = 0, got1 = 0, got2 = 0;

  // DUT fire counters (monitor) and phase bases (stimulus)
  int du = 0, dd1 = 0, dd2 = 0;
  int b_up = 0, b1 = 0, b2 = 0;
  bit inv_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs with queued expectations, count fires.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("up_ready",  int'(up_ready),  int'(e.upr));
      check("dn1_valid", int'(dn1_valid), int'(e.d1v));
      check("dn2_valid", int'(dn2_valid), int'(e.d2v));
      if (up_valid && up_ready)   du++;
      if (dn1_valid && dn1_ready) dd1++;
      if (dn2_valid && dn2_ready) dd2++;
      if (inv_en) begin
        n_chk++;
        if ((dd1 - b1) > (du - b_up) + 1 || (dd1 - b1) < (du - b_up) ||
            (dd2 - b2) > (du - b_up) + 1 || (dd2 - b2) < (du - b_up)) begin
          n_fail++;
          $display("FAIL fire_bound: up=%0d dn1=%0d dn2=%0d", du - b_up, dd1 - b1, dd2 - b2);
        end
      end
    end
  end

  // One cycle: drive inputs, push model expectation, advance model at the edge.
  task automatic step(input logic rst, input logic v, input logic r1, input logic r2,
                      output logic upf);
    exp_t e;
    reset = rst; up_valid = v; dn1_ready = r1; dn2_ready = r2;
    e.d1v = !rst && v && (got1 == ups);
    e.d2v = !rst && v && (got2 == ups);
    e.upr = !rst && ((got1 > ups) || r1) && ((got2 > ups) || r2);
    exp_q.push_back(e);
    @(posedge clock);
    upf = v && e.upr;
    if (rst) begin
      got1 = ups;  // partially delivered token is abandoned and re-offered
      got2 = ups;
    end else begin
      if (e.d1v && r1) got1++;
      if (e.d2v && r2) got2++;
      if (upf) ups++;
    end
    #1;
  endtask

  task automatic mark();
    b_up = du; b1 = dd1; b2 = dd2;
  endtask

  task automatic counts(input string name, input int n);
    check({name, "_up"},  du - b_up, n);
    check({name, "_dn1"}, dd1 - b1,  n);
    check({name, "_dn2"}, dd2 - b2,  n);
  endtask

  initial begin
    logic f;
    int tokens, cyc;
    reset = 1'b1; up_valid = 1'b0; dn1_ready = 1'b0; dn2_ready = 1'b0;
    @(posedge clock); #1;

    // Reset held with everything ready: outputs forced low, then immediate fire
    step(1, 1, 1, 1, f);
    step(1, 1, 1, 1, f);
    mark();
    step(0, 1, 1, 1, f);
    counts("post_reset", 1);

    // Full-rate broadcast
    mark();
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1, f);
    counts("full_rate", 8);

    // Staggered accept: dn1 at cycle 0, dn2 at cycle 3
    mark();
    step(0, 1, 1, 0, f);
    step(0, 1, 1, 0, f);
    step(0, 1, 0, 0, f);
    step(0, 1, 1, 1, f);
    counts("stagger", 1);
    step(0, 0, 0, 0, f);

    // Reset mid-token: dn1 took it, dn2 stalled, then reset
    mark();
    step(0, 1, 1, 0, f);
    step(0, 1, 0, 0, f);
    step(1, 1, 0, 0, f);
    step(0, 1, 0, 0, f);  // both re-offered
    step(0, 1, 1, 1, f);
    check("rst_mid_up", du - b_up, 1);
    check("rst_mid_dn1", dd1 - b1, 2);
    check("rst_mid_dn2", dd2 - b2, 1);

    // Random soak with upstream bubbles
    step(0, 0, 0, 0, f);
    mark();
    inv_en = 1'b1;
    tokens = 0;
    while (tokens < 32) begin
      if ($urandom_range(7, 0) >= 5) begin
        int gap = $urandom_range(3, 1);
        for (int g = 0; g < gap; g++)
          step(0, 0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), f);
      end
      f = 1'b0;
      cyc = 0;
      while (!f && cyc < 200) begin
        step(0, 1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), f);
        cyc++;
      end
      if (!f) begin
        n_chk++; n_fail++;
        $display("FAIL soak_timeout: token %0d not retired within %0d cycles", tokens, cyc);
        tokens = 32;
      end else tokens++;
    end
    step(0, 0, 0, 0, f);
    inv_en = 1'b0;
    counts("soak", 32);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
